// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with CTR_BITS-wide saturating direction
// counters for the five-stage MIPS pipeline.
//   - IF stage looks the table up combinationally with the fetch PC.
//   - MEM stage trains the table when a branch or jump resolves. The same
//     inputs also produce the mispredict/redirect signals used for the flush.
//
// Optional feature macro: BRANCH_PREDICTOR_STATS_EN
//   defined     -> 32-bit saturating lookup and mispredict counters.
//   not defined -> no counter flops; stat_lookups/stat_mispred read as 0.
//
// Parameter legality: IDX_BITS + TAG_BITS + 2 must not exceed 32, and
// CTR_BITS must be at least 1.
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 8,
  parameter int CTR_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  // fetch-side lookup
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  // resolve-side training
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_jump,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  input  logic        inv_all,
  output logic        mispredict,
  output logic [31:0] correct_pc,
  // statistics
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispred
);

  // Update protocol: there is no valid/ready handshake. upd_valid is a
  // single-cycle strobe qualifying upd_* for exactly one posedge; the
  // predictor always accepts it (no backpressure), at most one resolution
  // per cycle. inv_all is a level sampled on posedge and beats upd_valid.

  localparam int ENTRIES = 1 << IDX_BITS;

  localparam logic [CTR_BITS-1:0] CTR_ONE        = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_ZERO       = '0;
  localparam logic [CTR_BITS-1:0] CTR_MAX        = {CTR_BITS{1'b1}};
  // MSB-only pattern: the weakest "taken" state
  localparam logic [CTR_BITS-1:0] CTR_WEAK_TAKEN = CTR_ONE << (CTR_BITS - 1);
  // One below it: the weakest "not taken" state, used as the reset value
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NOT   = CTR_WEAK_TAKEN - CTR_ONE;

  // ---------------------------------------------------------------------------
  // Table storage
  // valid and ctr are reset; tag and target are only meaningful while valid
  // is set, so they are plain data flops written on allocation/training.
  // ---------------------------------------------------------------------------
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  // ---------------------------------------------------------------------------
  // Lookup (zero latency, reads the pre-update table contents)
  // ---------------------------------------------------------------------------
  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;

  assign lk_idx = if_pc[IDX_BITS+1:2];
  assign lk_tag = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign pred_taken  = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? target_q[lk_idx] : (if_pc + 32'd4);

  // ---------------------------------------------------------------------------
  // Resolution: mispredict detection and redirect PC
  // A taken branch whose predicted target differs is a mispredict even when
  // the direction was right; a correctly predicted not-taken never is.
  // ---------------------------------------------------------------------------
  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));

  assign correct_pc = upd_taken ? upd_target : (upd_pc + 32'd4);

  // ---------------------------------------------------------------------------
  // Training decode
  // ---------------------------------------------------------------------------
  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;
  logic [CTR_BITS-1:0] up_ctr_cur;

  assign up_idx     = upd_pc[IDX_BITS+1:2];
  assign up_tag     = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr_cur = ctr_q[up_idx];

  logic                alloc;      // miss + taken: claim the entry
  logic                ctr_we;     // write ctr_nxt into the indexed entry
  logic                target_we;  // write upd_target into the indexed entry
  logic [CTR_BITS-1:0] ctr_nxt;

  // Decide what the resolving instruction does to its entry; inv_all drops it
  always_comb begin
    alloc     = 1'b0;
    ctr_we    = 1'b0;
    target_we = 1'b0;
    ctr_nxt   = up_ctr_cur;
    if (upd_valid && !inv_all) begin
      if (up_hit) begin
        ctr_we = 1'b1;
        if (upd_is_jump) begin
          ctr_nxt   = CTR_MAX;
          target_we = 1'b1;
        end else if (upd_taken) begin
          ctr_nxt   = (up_ctr_cur == CTR_MAX) ? CTR_MAX : (up_ctr_cur + CTR_ONE);
          target_we = 1'b1;
        end else begin
          ctr_nxt   = (up_ctr_cur == CTR_ZERO) ? CTR_ZERO : (up_ctr_cur - CTR_ONE);
        end
      end else if (upd_taken) begin
        // Miss on a taken instruction replaces whatever aliased there
        alloc     = 1'b1;
        ctr_we    = 1'b1;
        target_we = 1'b1;
        ctr_nxt   = upd_is_jump ? CTR_MAX : CTR_WEAK_TAKEN;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State updates
  // ---------------------------------------------------------------------------

  // Valid bits: cleared by reset or inv_all, set on allocation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (inv_all) begin
      valid_q <= '0;
    end else if (alloc) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Direction counters: reset to weakly-not-taken, trained by resolutions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_WEAK_NOT;
      end
    end else if (ctr_we) begin
      ctr_q[up_idx] <= ctr_nxt;
    end
  end

  // Tag and target payload: written on allocation / taken training only
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[up_idx] <= up_tag;
    end
    if (target_we) begin
      target_q[up_idx] <= upd_target;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] lookups_q;
  logic [31:0] mispred_q;

  // Saturating event counters, cleared only by reset (inv_all leaves them)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      if (if_req && (lookups_q != 32'hFFFF_FFFF)) begin
        lookups_q <= lookups_q + 32'd1;
      end
      if (mispredict && (mispred_q != 32'hFFFF_FFFF)) begin
        mispred_q <= mispred_q + 32'd1;
      end
    end
  end

  assign stat_lookups = lookups_q;
  assign stat_mispred = mispred_q;
`else
  // if_req only feeds the lookup counter; keep it referenced when absent
  logic unused_if_req;
  assign unused_if_req = if_req;

  assign stat_lookups = '0;
  assign stat_mispred = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor (defaults IDX=4, TAG=8, CTR=2).
// Directed scenarios followed by a randomized run checked against a
// behavioural table model. Statistics expectations follow the
// BRANCH_PREDICTOR_STATS_EN build option.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int IDX  = 4;
  localparam int TAG  = 8;
  localparam int CTR  = 2;
  localparam int N    = 1 << IDX;
  localparam int CMAX = (1 << CTR) - 1;
  localparam int CWT  = 1 << (CTR - 1);

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        inv_all;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispred;

  branch_predictor #(.IDX_BITS(IDX), .TAG_BITS(TAG), .CTR_BITS(CTR)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .inv_all(inv_all), .mispredict(mispredict), .correct_pc(correct_pc),
    .stat_lookups(stat_lookups), .stat_mispred(stat_mispred)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------------------------------------------------------------------
  // Reference model: a table of entries with integer counters
  // ---------------------------------------------------------------------------
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  logic [31:0] m_lk;
  logic [31:0] m_mp;

  // Scoreboard of expected {pred_taken, pred_target}
  logic [32:0] exp_q[$];

  function automatic int f_idx(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic int unsigned f_tag(input logic [31:0] pc);
    return (pc >> (IDX + 2)) % (1 << TAG);
  endfunction

  function automatic bit f_hit(input logic [31:0] pc);
    return m_valid[f_idx(pc)] && (m_tag[f_idx(pc)] == f_tag(pc));
  endfunction

  function automatic bit exp_taken(input logic [31:0] pc);
    return f_hit(pc) && (m_ctr[f_idx(pc)] >= CWT);
  endfunction

  function automatic logic [31:0] exp_target(input logic [31:0] pc);
    return exp_taken(pc) ? m_tgt[f_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit exp_mispred();
    if (!upd_valid) return 1'b0;
    if (upd_taken != upd_pred_taken) return 1'b1;
    return upd_taken && (upd_target != upd_pred_target);
  endfunction

  function automatic logic [31:0] exp_correct();
    return upd_taken ? upd_target : upd_pc + 32'd4;
  endfunction

  function automatic logic [31:0] exp_lookups();
`ifdef BRANCH_PREDICTOR_STATS_EN
    return m_lk;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_mispreds();
`ifdef BRANCH_PREDICTOR_STATS_EN
    return m_mp;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = CWT - 1;
    end
    m_lk = 32'd0;
    m_mp = 32'd0;
  endtask

  // Apply what the upcoming posedge does, using the inputs held across it
  task automatic model_edge();
    int  i;
    bit  hit;
    i   = f_idx(upd_pc);
    hit = f_hit(upd_pc);
    if (if_req && m_lk != 32'hFFFF_FFFF) m_lk = m_lk + 32'd1;
    if (exp_mispred() && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 32'd1;
    if (inv_all) begin
      for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
    end else if (upd_valid) begin
      if (hit && upd_is_jump) begin
        m_ctr[i] = CMAX;
        m_tgt[i] = upd_target;
      end else if (hit && upd_taken) begin
        m_ctr[i] = (m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1;
        m_tgt[i] = upd_target;
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end else if (upd_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = f_tag(upd_pc);
        m_tgt[i]   = upd_target;
        m_ctr[i]   = upd_is_jump ? CMAX : CWT;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req          = 1'b0;
    if_pc           = 32'd0;
    upd_valid       = 1'b0;
    upd_pc          = 32'd0;
    upd_is_jump     = 1'b0;
    upd_taken       = 1'b0;
    upd_target      = 32'd0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = 32'd0;
    inv_all         = 1'b0;
  endtask

  task automatic drive_fetch(input logic [31:0] pc);
    if_req = 1'b1;
    if_pc  = pc;
    #1;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic jump, input logic taken,
                           input logic [31:0] tgt, input logic ptaken,
                           input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_is_jump     = jump;
    upd_taken       = taken;
    upd_target      = tgt;
    upd_pred_taken  = ptaken;
    upd_pred_target = ptgt;
    #1;
  endtask

  task automatic clear_upd();
    upd_valid = 1'b0;
    inv_all   = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
        (32'($urandom_range(0, 1)) << 20);
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    drive_fetch(32'h40);
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL cold_taken: got %0b want 0", pred_taken); else n_pass++;
    n_checks++; if (pred_target !== 32'h44) $display("FAIL cold_target: got %h want 00000044", pred_target); else n_pass++;
    n_checks++; if (mispredict !== 1'b0) $display("FAIL cold_mispredict: got %0b want 0", mispredict); else n_pass++;
    n_checks++; if (stat_lookups !== 32'd0) $display("FAIL cold_lookups: got %0d want 0", stat_lookups); else n_pass++;
    n_checks++; if (stat_mispred !== 32'd0) $display("FAIL cold_mispred: got %0d want 0", stat_mispred); else n_pass++;
  endtask

  task automatic test_train_taken();
    drive_fetch(32'h40);
    drive_upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL train_same_cycle_taken: got %0b want 0", pred_taken); else n_pass++;
    n_checks++; if (pred_target !== 32'h44) $display("FAIL train_same_cycle_target: got %h want 00000044", pred_target); else n_pass++;
    n_checks++; if (mispredict !== 1'b1) $display("FAIL train_mispredict: got %0b want 1", mispredict); else n_pass++;
    n_checks++; if (correct_pc !== 32'h100) $display("FAIL train_correct_pc: got %h want 00000100", correct_pc); else n_pass++;
    tick();
    clear_upd();
    n_checks++; if (pred_taken !== 1'b1) $display("FAIL train_next_taken: got %0b want 1", pred_taken); else n_pass++;
    n_checks++; if (pred_target !== 32'h100) $display("FAIL train_next_target: got %h want 00000100", pred_target); else n_pass++;
    n_checks++; if (stat_lookups !== exp_lookups()) $display("FAIL train_lookups: got %0d want %0d", stat_lookups, exp_lookups()); else n_pass++;
    n_checks++; if (stat_mispred !== exp_mispreds()) $display("FAIL train_mispred_stat: got %0d want %0d", stat_mispred, exp_mispreds()); else n_pass++;
  endtask

  // From ctr=2: NT,NT,NT (floor at 0), then T,T,T,T (ceiling at 3), then NT
  task automatic test_hysteresis();
    bit outc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit want [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int s = 0; s < 8; s++) begin
      drive_fetch(32'h40);
      drive_upd(32'h40, 1'b0, outc[s], 32'h100, exp_taken(32'h40), exp_target(32'h40));
      tick();
      clear_upd();
      n_checks++; if (pred_taken !== want[s]) $display("FAIL hyst_taken_step%0d: got %0b want %0b", s, pred_taken, want[s]); else n_pass++;
      n_checks++; if (pred_target !== (want[s] ? 32'h100 : 32'h44)) $display("FAIL hyst_target_step%0d: got %h want %h", s, pred_target, want[s] ? 32'h100 : 32'h44); else n_pass++;
    end
  endtask

  task automatic test_aliasing();
    drive_fetch(32'h440);
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL alias_miss_taken: got %0b want 0", pred_taken); else n_pass++;
    n_checks++; if (pred_target !== 32'h444) $display("FAIL alias_miss_target: got %h want 00000444", pred_target); else n_pass++;
    drive_upd(32'h440, 1'b0, 1'b1, 32'h300, 1'b0, 32'h444);
    tick();
    clear_upd();
    drive_fetch(32'h40);
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL alias_evicted_taken: got %0b want 0", pred_taken); else n_pass++;
    n_checks++; if (pred_target !== 32'h44) $display("FAIL alias_evicted_target: got %h want 00000044", pred_target); else n_pass++;
    drive_fetch(32'h440);
    n_checks++; if (pred_target !== 32'h300) $display("FAIL alias_new_target: got %h want 00000300", pred_target); else n_pass++;
  endtask

  // Jumps allocate strongly taken and force strongly taken on hit
  task automatic test_jump();
    drive_fetch(32'h100);
    drive_upd(32'h100, 1'b1, 1'b1, 32'h800, 1'b0, 32'h104);
    tick();
    clear_upd();
    n_checks++; if (pred_target !== 32'h800) $display("FAIL jump_alloc_target: got %h want 00000800", pred_target); else n_pass++;
    drive_upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h800);
    tick();
    clear_upd();
    n_checks++; if (pred_taken !== 1'b1) $display("FAIL jump_strong_after_nt: got %0b want 1", pred_taken); else n_pass++;
    n_checks++; if (pred_target !== 32'h800) $display("FAIL jump_nt_keeps_target: got %h want 00000800", pred_target); else n_pass++;
    drive_upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h800);
    tick();
    clear_upd();
    n_checks++; if (pred_target !== 32'h104) $display("FAIL jump_weak_after_2nt: got %h want 00000104", pred_target); else n_pass++;
    drive_upd(32'h100, 1'b1, 1'b1, 32'h900, 1'b0, 32'h104);
    tick();
    clear_upd();
    n_checks++; if (pred_target !== 32'h900) $display("FAIL jump_hit_retarget: got %h want 00000900", pred_target); else n_pass++;
  endtask

  task automatic test_mispredict();
    logic [31:0] pcs  [5] = '{32'hC0, 32'hC0, 32'h80, 32'hC0, 32'hC0};
    logic        tk   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] tg   [5] = '{32'h200, 32'h200, 32'h500, 32'h200, 32'h200};
    logic        ptk  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] ptg  [5] = '{32'hC4, 32'h1FC, 32'h84, 32'h200, 32'h200};
    logic        wmp  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] wcpc [5] = '{32'h200, 32'h200, 32'h84, 32'h200, 32'hC4};
    for (int s = 0; s < 5; s++) begin
      if_req = 1'b0;
      drive_upd(pcs[s], 1'b0, tk[s], tg[s], ptk[s], ptg[s]);
      n_checks++; if (mispredict !== wmp[s]) $display("FAIL mp_flag_case%0d: got %0b want %0b", s, mispredict, wmp[s]); else n_pass++;
      n_checks++; if (correct_pc !== wcpc[s]) $display("FAIL mp_correct_pc_case%0d: got %h want %h", s, correct_pc, wcpc[s]); else n_pass++;
      tick();
      clear_upd();
      n_checks++; if (stat_mispred !== exp_mispreds()) $display("FAIL mp_stat_case%0d: got %0d want %0d", s, stat_mispred, exp_mispreds()); else n_pass++;
    end
  endtask

  task automatic test_inv_all();
    drive_upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
    tick();
    clear_upd();
    drive_fetch(32'h40);
    n_checks++; if (pred_taken !== 1'b1) $display("FAIL inv_pretrain_hit: got %0b want 1", pred_taken); else n_pass++;
    inv_all = 1'b1;
    drive_upd(32'h80, 1'b0, 1'b1, 32'h180, 1'b0, 32'h84);
    tick();
    clear_upd();
    drive_fetch(32'h40);
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL inv_miss_0x40: got %0b want 0", pred_taken); else n_pass++;
    drive_fetch(32'h80);
    n_checks++; if (pred_target !== 32'h84) $display("FAIL inv_miss_0x80: got %h want 00000084", pred_target); else n_pass++;
    drive_fetch(32'hC0);
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL inv_miss_0xc0: got %0b want 0", pred_taken); else n_pass++;
    n_checks++; if (stat_mispred !== exp_mispreds()) $display("FAIL inv_mispred_stat: got %0d want %0d", stat_mispred, exp_mispreds()); else n_pass++;
  endtask

  task automatic test_async_reset();
    drive_fetch(32'h40);
    drive_upd(32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44);
    tick();
    clear_upd();
    n_checks++; if (pred_taken !== 1'b1) $display("FAIL arst_pre_hit: got %0b want 1", pred_taken); else n_pass++;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL arst_taken: got %0b want 0", pred_taken); else n_pass++;
    n_checks++; if (stat_lookups !== 32'd0) $display("FAIL arst_lookups: got %0d want 0", stat_lookups); else n_pass++;
    n_checks++; if (stat_mispred !== 32'd0) $display("FAIL arst_mispred: got %0d want 0", stat_mispred); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++; if (pred_target !== 32'h44) $display("FAIL arst_entries_lost: got %h want 00000044", pred_target); else n_pass++;
    n_checks++; if (stat_lookups !== exp_lookups()) $display("FAIL arst_resume_lookups: got %0d want %0d", stat_lookups, exp_lookups()); else n_pass++;
  endtask

  task automatic test_random();
    logic [32:0] want;
    for (int c = 0; c < 400; c++) begin
      if_req      = 1'($urandom_range(0, 1));
      if_pc       = rand_pc();
      upd_valid   = 1'($urandom_range(0, 1));
      upd_pc      = rand_pc();
      upd_is_jump = ($urandom_range(0, 4) == 0);
      upd_taken   = upd_is_jump ? 1'b1 : 1'($urandom_range(0, 1));
      upd_target  = $urandom & 32'hFFFF_FFFC;
      case ($urandom_range(0, 3))
        0: begin upd_pred_taken = 1'($urandom_range(0, 1)); upd_pred_target = $urandom & 32'hFFFF_FFFC; end
        1: begin upd_pred_taken = upd_taken; upd_pred_target = upd_target; end
        default: begin upd_pred_taken = exp_taken(upd_pc); upd_pred_target = exp_target(upd_pc); end
      endcase
      inv_all = ($urandom_range(0, 31) == 0);
      #1;
      exp_q.push_back({exp_taken(if_pc), exp_target(if_pc)});
      want = exp_q.pop_front();
      n_checks++; if ({pred_taken, pred_target} !== want) $display("FAIL rand_lookup_c%0d pc=%h: got %0b/%h want %0b/%h", c, if_pc, pred_taken, pred_target, want[32], want[31:0]); else n_pass++;
      n_checks++; if (mispredict !== exp_mispred()) $display("FAIL rand_mispredict_c%0d: got %0b want %0b", c, mispredict, exp_mispred()); else n_pass++;
      if (upd_valid) begin
        n_checks++; if (correct_pc !== exp_correct()) $display("FAIL rand_correct_pc_c%0d: got %h want %h", c, correct_pc, exp_correct()); else n_pass++;
      end
      tick();
      n_checks++; if (stat_lookups !== exp_lookups() || stat_mispred !== exp_mispreds()) $display("FAIL rand_stats_c%0d: got %0d/%0d want %0d/%0d", c, stat_lookups, stat_mispred, exp_lookups(), exp_mispreds()); else n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    idle();
    test_reset();
    test_train_taken();
    test_hysteresis();
    test_aliasing();
    test_jump();
    test_mispredict();
    test_inv_all();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
